morph3x3_filter: RTL and testbench

Parametrised 3×3 binary/greyscale morphology stage for the pupil-detection pixel pipeline. It is the successor to the fixed 8-bit OR-dilation block. It accepts a raster pixel stream, keeps its own two line buffers, and applies a run-time-selectable operator: pass-through, dilation (bitwise OR of the 3×3 neighbourhood) or erosion (bitwise AND). It emits a same-size output frame with defined border handling and an end-of-frame flush. It sits between the thresholding stage and the pupil-centroid logic, and can be cascaded for open/close operations.

---
 rtl/morph3x3_filter.sv | 168 ++++++++++++++++
 tb/tb_morph3x3_filter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph3x3_filter.sv
// morph3x3_filter: streaming 3x3 pass / dilate (OR) / erode (AND) with two internal line buffers.
// Optional feature macro MORPH_ERR_EN: adds the err port and restarts the frame on an unexpected sof.
module morph3x3_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            mode,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef MORPH_ERR_EN
  output logic                  err,
`endif
  output logic                  busy
);

  localparam int CLW = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int FW  = $clog2(IMG_WIDTH + 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0]  ROW_ONE  = RW'(1);
  localparam logic [FW-1:0]  FL_LAST  = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                r_state;
  logic [CLW-1:0]        r_col, r_ocol, r_ocol_p1;
  logic [RW-1:0]         r_row, r_orow, r_orow_p1;
  logic [FW-1:0]         r_fcnt;
  logic [1:0]            r_mode_q, r_mode_p1;
  logic                  r_vld_p1, r_out_valid, r_out_sof;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_win_p1 [3][3];
`ifdef MORPH_ERR_EN
  logic                  r_err;
`endif

  logic                  w_accept, w_restart, w_start, w_pix, w_inject, w_event, w_prod, w_last_in;
  logic [CLW-1:0]        w_wcol;
  logic [DATA_WIDTH-1:0] w_din, w_op, w_or, w_and;
  logic [2:0]            w_rmask, w_cmask;

  assign w_accept  = in_valid && in_ready;
`ifdef MORPH_ERR_EN
  assign w_restart = w_accept && in_sof && (r_state == S_RUN);
`else
  assign w_restart = 1'b0;
`endif
  assign w_start   = (w_accept && in_sof && (r_state == S_IDLE)) || w_restart;
  assign w_pix     = w_accept && (r_state == S_RUN) && !w_restart;
  assign w_inject  = (r_state == S_FLUSH);
  assign w_event   = w_start || w_pix || w_inject;
  // Input index k+IMG_WIDTH+1 completes the window of output k; the first W+1 pixels only fill it.
  assign w_prod    = w_inject || (w_pix && (r_row != '0) && !((r_row == ROW_ONE) && (r_col == '0)));
  assign w_last_in = w_pix && (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_wcol    = w_start ? '0 : r_col;
  assign w_din     = w_inject ? '0 : in_data;

  // Stage p1: line buffers and the 3x3 window shift one column per accepted or injected pixel.
  always_ff @(posedge clock) begin
    if (w_event) begin
      r_lb0[w_wcol] <= w_din;
      r_lb1[w_wcol] <= r_lb0[w_wcol];
      for (int r = 0; r < 3; r++) begin
        r_win_p1[r][0] <= r_win_p1[r][1];
        r_win_p1[r][1] <= r_win_p1[r][2];
      end
      r_win_p1[0][2] <= r_lb1[w_wcol];
      r_win_p1[1][2] <= r_lb0[w_wcol];
      r_win_p1[2][2] <= w_din;
    end
    r_orow_p1 <= r_orow;
    r_ocol_p1 <= r_ocol;
    r_mode_p1 <= r_mode_q;
  end

  // Out-of-image neighbours are dropped, which is the same as substituting the operator identity.
  always_comb begin
    w_rmask = {r_orow_p1 != ROW_LAST, 1'b1, r_orow_p1 != '0};
    w_cmask = {r_ocol_p1 != COL_LAST, 1'b1, r_ocol_p1 != '0};
    w_or    = '0;
    w_and   = '1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (w_rmask[i] && w_cmask[j]) begin
          w_or  = w_or | r_win_p1[i][j];
          w_and = w_and & r_win_p1[i][j];
        end
      end
    end
    case (r_mode_p1)
      2'b01:   w_op = w_or;
      2'b10:   w_op = w_and;
      default: w_op = r_win_p1[1][1];
    endcase
  end

  // Stage p2: control FSM and the operator output register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_ocol      <= '0;
      r_orow      <= '0;
      r_fcnt      <= '0;
      r_mode_q    <= '0;
      r_vld_p1    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_data  <= '0;
`ifdef MORPH_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_state  <= S_RUN;
        r_mode_q <= mode;
        r_col    <= CLW'(1);
        r_row    <= '0;
        r_ocol   <= '0;
        r_orow   <= '0;
      end else if (w_pix) begin
        r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        if (r_col == COL_LAST) r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        if (w_last_in) begin
          r_state <= S_FLUSH;
          r_fcnt  <= '0;
        end
      end else if (w_inject) begin
        r_col  <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        r_fcnt <= r_fcnt + 1'b1;
        if (r_fcnt == FL_LAST) r_state <= S_IDLE;
      end
      if (w_prod) begin
        r_ocol <= (r_ocol == COL_LAST) ? '0 : r_ocol + 1'b1;
        if (r_ocol == COL_LAST) r_orow <= (r_orow == ROW_LAST) ? '0 : r_orow + 1'b1;
      end
      r_vld_p1    <= w_prod;
      r_out_valid <= r_vld_p1 && !w_restart;
      r_out_sof   <= r_vld_p1 && !w_restart && (r_orow_p1 == '0) && (r_ocol_p1 == '0);
      if (r_vld_p1) r_out_data <= w_op;
`ifdef MORPH_ERR_EN
      r_err <= w_restart;
`endif
    end
  end

  assign in_ready  = (r_state != S_FLUSH);
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE) || r_vld_p1 || r_out_valid;
`ifdef MORPH_ERR_EN
  assign err       = r_err;
`endif

endmodule

// File: tb/tb_morph3x3_filter.sv
// Self-checking bench for morph3x3_filter on a 4x3 image, checked against a neighbourhood reference model.
`timescale 1ns/1ps
module tb_morph3x3_filter;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          in_ready, out_valid, out_sof, busy;
  logic [DW-1:0] out_data;
`ifdef MORPH_ERR_EN
  logic          err;
`endif

  morph3x3_filter #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .mode(mode), .in_ready(in_ready), .out_valid(out_valid), .out_sof(out_sof),
    .out_data(out_data),
`ifdef MORPH_ERR_EN
    .err(err),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [DW-1:0] frame [N];

  logic [DW-1:0] oq[$];
  bit            sq[$];
  int            ocq[$];
  bit            obq[$];
  int            acq[$];
  int            rdy_low, busy_fall, err_cnt, err_cyc;
  bit            prev_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acq.push_back(cyc);
      if (out_valid) begin
        oq.push_back(out_data); sq.push_back(out_sof); ocq.push_back(cyc); obq.push_back(busy);
      end
      if (!in_ready) rdy_low++;
      if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
      prev_busy = busy;
`ifdef MORPH_ERR_EN
      if (err) begin err_cnt++; err_cyc = cyc; end
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    oq.delete(); sq.delete(); ocq.delete(); obq.delete(); acq.delete();
    rdy_low = 0; busy_fall = -1; err_cnt = 0; err_cyc = -1; prev_busy = busy;
  endtask

  // Dilation/erosion over the in-image part of the 3x3 neighbourhood, straight from the definition.
  function automatic logic [DW-1:0] model_px(input logic [1:0] md, input int k);
    int r, c;
    logic [DW-1:0] acc;
    r = k / W;
    c = k % W;
    if (md == 2'b01) acc = '0;
    else if (md == 2'b10) acc = '1;
    else return frame[k];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          acc = (md == 2'b01) ? (acc | frame[(r+dr)*W + c+dc]) : (acc & frame[(r+dr)*W + c+dc]);
    return acc;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy === 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout busy=%b required 0", busy); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // gap: 0 continuous, 1 toggle every cycle, 2 random idle cycles
  task automatic drive_frame(input logic [1:0] md, input logic [1:0] md2, input int sw,
                             input int gap, input int junk, input int sof2, input bit nowait);
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_data = DW'($urandom); mode = md;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    clear_mon();
    for (int i = 0; i < N; i++) begin
      if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      in_valid = 1'b1; in_sof = (i == 0) || (i == sof2); in_data = frame[i];
      mode = (i < sw) ? md : md2;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!nowait) wait_idle();
  endtask

  task automatic fill_random(input bit binary);
    for (int i = 0; i < N; i++)
      frame[i] = binary ? ($urandom_range(0, 1) == 1 ? 8'hFF : 8'h00) : DW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    n_tests++; if (out_sof !== 1'b0) begin n_fail++; $display("FAIL rst_out_sof got %b required 0", out_sof); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got %h required 00", out_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b required 0", busy); end
`ifdef MORPH_ERR_EN
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b required 0", err); end
`endif
  endtask

  task automatic test_dilate_point();
    logic [DW-1:0] exp;
    for (int i = 0; i < N; i++) frame[i] = 8'h00;
    frame[1*W + 1] = 8'hFF;
    drive_frame(2'b01, 2'b01, N, 0, 0, -1, 1'b0);
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL dilate_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      exp = (k % W < 3) ? 8'hFF : 8'h00;
      n_tests++;
      if ({sq[k], oq[k]} !== {k == 0, exp}) begin
        n_fail++; $display("FAIL dilate_px k=%0d got sof=%b data=%h required sof=%b data=%h", k, sq[k], oq[k], k == 0, exp);
      end
    end
  endtask

  task automatic test_erode_corner();
    logic [DW-1:0] exp;
    for (int i = 0; i < N; i++) frame[i] = 8'hFF;
    frame[0] = 8'h00;
    drive_frame(2'b10, 2'b10, N, 0, 0, -1, 1'b0);
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL erode_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      exp = (k / W <= 1 && k % W <= 1) ? 8'h00 : 8'hFF;
      n_tests++;
      if ({sq[k], oq[k]} !== {k == 0, exp}) begin
        n_fail++; $display("FAIL erode_px k=%0d got sof=%b data=%h required sof=%b data=%h", k, sq[k], oq[k], k == 0, exp);
      end
    end
  endtask

  task automatic test_pass_ramp();
    for (int i = 0; i < N; i++) frame[i] = DW'(i);
    drive_frame(2'b00, 2'b00, N, 0, 0, -1, 1'b0);
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL pass_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (oq[k] !== DW'(k)) begin n_fail++; $display("FAIL pass_px k=%0d got %h required %h", k, oq[k], DW'(k)); end
    end
    n_tests++;
    if (ocq[0] !== acq[W+1] + 2) begin
      n_fail++; $display("FAIL pass_latency got cycle %0d required %0d", ocq[0], acq[W+1] + 2);
    end
  endtask

  task automatic test_gaps();
    fill_random(1'b0);
    drive_frame(2'b01, 2'b01, N, 1, 0, -1, 1'b0);
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL gaps_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (oq[k] !== model_px(2'b01, k)) begin
        n_fail++; $display("FAIL gaps_px k=%0d got %h required %h", k, oq[k], model_px(2'b01, k));
      end
    end
    n_tests++;
    if (rdy_low != W + 1) begin n_fail++; $display("FAIL gaps_ready_low got %0d required %0d", rdy_low, W + 1); end
    n_tests++;
    if (obq[N-1] !== 1'b1) begin n_fail++; $display("FAIL gaps_busy_last got %b required 1", obq[N-1]); end
    n_tests++;
    if (busy_fall != ocq[N-1] + 1) begin
      n_fail++; $display("FAIL gaps_busy_fall got cycle %0d required %0d", busy_fall, ocq[N-1] + 1);
    end
  endtask

  task automatic test_mode_change();
    fill_random(1'b1);
    drive_frame(2'b01, 2'b10, 6, 0, 0, -1, 1'b0);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (oq[k] !== model_px(2'b01, k)) begin
        n_fail++; $display("FAIL modechg_or k=%0d got %h required %h", k, oq[k], model_px(2'b01, k));
      end
    end
    fill_random(1'b1);
    drive_frame(2'b10, 2'b01, 3, 0, 0, -1, 1'b0);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (oq[k] !== model_px(2'b10, k)) begin
        n_fail++; $display("FAIL modechg_and k=%0d got %h required %h", k, oq[k], model_px(2'b10, k));
      end
    end
  endtask

  task automatic test_sof_midframe();
`ifdef MORPH_ERR_EN
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = DW'($urandom); mode = 2'b01;
      @(posedge clk); #1;
    end
    fill_random(1'b1);
    drive_frame(2'b10, 2'b10, N, 0, 0, -1, 1'b0);
    n_tests++;
    if (err_cnt != 1) begin n_fail++; $display("FAIL err_pulse_len got %0d required 1", err_cnt); end
    n_tests++;
    if (err_cyc != acq[0] + 1) begin n_fail++; $display("FAIL err_pulse_cycle got %0d required %0d", err_cyc, acq[0] + 1); end
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL restart_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if ({sq[k], oq[k]} !== {k == 0, model_px(2'b10, k)}) begin
        n_fail++; $display("FAIL restart_px k=%0d got sof=%b data=%h required sof=%b data=%h", k, sq[k], oq[k], k == 0, model_px(2'b10, k));
      end
    end
`else
    fill_random(1'b1);
    drive_frame(2'b01, 2'b01, N, 0, 0, 6, 1'b0);
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL midsof_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if ({sq[k], oq[k]} !== {k == 0, model_px(2'b01, k)}) begin
        n_fail++; $display("FAIL midsof_px k=%0d got sof=%b data=%h required sof=%b data=%h", k, sq[k], oq[k], k == 0, model_px(2'b01, k));
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [1:0] md;
    for (int it = 0; it < 6; it++) begin
      md = 2'($urandom_range(0, 3));
      fill_random(it[0]);
      drive_frame(md, 2'($urandom_range(0, 3)), $urandom_range(1, N), it % 3, $urandom_range(0, 3), -1, 1'b0);
      n_tests++;
      if (oq.size() != N) begin n_fail++; $display("FAIL rand_count it=%0d got %0d required %0d", it, oq.size(), N); end
      for (int k = 0; k < N; k++) begin
        n_tests++;
        if ({sq[k], oq[k]} !== {k == 0, model_px(md, k)}) begin
          n_fail++; $display("FAIL rand_px it=%0d mode=%0d k=%0d got sof=%b data=%h required sof=%b data=%h", it, md, k, sq[k], oq[k], k == 0, model_px(md, k));
        end
        n_tests++;
        if (k < N - W - 1) begin
          if (ocq[k] !== acq[k+W+1] + 2) begin
            n_fail++; $display("FAIL rand_latency it=%0d k=%0d got cycle %0d required %0d", it, k, ocq[k], acq[k+W+1] + 2);
          end
        end else if (ocq[k] !== ocq[N-W-2] + (k - (N - W - 2))) begin
          n_fail++; $display("FAIL rand_flush_cycle it=%0d k=%0d got %0d required %0d", it, k, ocq[k], ocq[N-W-2] + (k - (N - W - 2)));
        end
      end
    end
  endtask

  task automatic test_rst_flush();
    fill_random(1'b0);
    drive_frame(2'b01, 2'b01, N, 0, 0, -1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstflush_out_valid got %b required 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstflush_in_ready got %b required 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstflush_busy got %b required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (12) @(posedge clk);
    #1;
    n_tests++;
    if (oq.size() != 0) begin n_fail++; $display("FAIL rstflush_no_output got %0d outputs required 0", oq.size()); end
    fill_random(1'b1);
    drive_frame(2'b10, 2'b10, N, 0, 0, -1, 1'b0);
    n_tests++;
    if (oq.size() != N) begin n_fail++; $display("FAIL rstflush_recover_count got %0d required %0d", oq.size(), N); end
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (oq[k] !== model_px(2'b10, k)) begin
        n_fail++; $display("FAIL rstflush_recover_px k=%0d got %h required %h", k, oq[k], model_px(2'b10, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_dilate_point();
    test_erode_corner();
    test_pass_ramp();
    test_gaps();
    test_mode_change();
    test_sof_midframe();
    test_random();
    test_rst_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
